// File: rtl/simple_dual_port_ram_if.sv
// Bus bundle for simple_dual_port_ram: one write port, one read port.
// The master (e.g. the FIFO pointer logic) drives requests and samples data_out.
interface simple_dual_port_ram_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 9
);
   logic                  write_enable;
   logic [ADDR_WIDTH-1:0] write_addr;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  read_enable;
   logic [ADDR_WIDTH-1:0] read_addr;
   logic [DATA_WIDTH-1:0] data_out;

   modport master (
      output write_enable, write_addr, data_in, read_enable, read_addr,
      input  data_out
   );

   modport slave (
      input  write_enable, write_addr, data_in, read_enable, read_addr,
      output data_out
   );
endinterface

// File: rtl/simple_dual_port_ram.sv
// Simple dual-port RAM, single clock, with a LATENCY-deep registered read
// pipeline. Memory contents are never reset; only the read pipeline is.
// Optional build macro RAM_RDW_BYPASS_EN: same-address read-during-write
// returns the incoming write data (write-first) instead of the old contents.
module simple_dual_port_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 9,
   parameter int LATENCY    = 3
) (
   input logic                  clk,
   input logic                  reset,
   simple_dual_port_ram_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   // A single-stage pipeline cannot provide both the array read and the
   // output register, so reject it at elaboration.
   generate
      if (LATENCY < 2) begin : g_latency_check
         $fatal(1, "simple_dual_port_ram: LATENCY must be >= 2");
      end
   endgenerate

   logic [DATA_WIDTH-1:0]              mem_q [DEPTH];
   logic [DATA_WIDTH-1:0]              rd_word;
   logic [LATENCY-1:0][DATA_WIDTH-1:0] stage_q;
   logic [LATENCY-1:0][DATA_WIDTH-1:0] stage_d;

   // Array read word; read-first by default, optional write-first bypass.
   always_comb begin
      rd_word = mem_q[bus.read_addr];
`ifdef RAM_RDW_BYPASS_EN
      if (bus.write_enable && (bus.write_addr == bus.read_addr)) begin
         rd_word = bus.data_in;
      end
`else
`endif
   end

   // Pipeline next state: stage 0 loads on a read and otherwise holds,
   // later stages shift every clock so the last read settles and holds.
   always_comb begin
      stage_d = stage_q;
      if (bus.read_enable) begin
         stage_d[0] = rd_word;
      end
      for (int i = 1; i < LATENCY; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // Storage array write; deliberately outside reset so it maps to block RAM.
   always_ff @(posedge clk) begin
      if (bus.write_enable) begin
         mem_q[bus.write_addr] <= bus.data_in;
      end
   end

   // Read pipeline registers, cleared asynchronously to drop in-flight reads.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign bus.data_out = stage_q[LATENCY-1];
endmodule

// File: tb/tb_simple_dual_port_ram.sv
// Scoreboard bench for simple_dual_port_ram: two instances (LATENCY 3 and 2)
// driven by the same stimulus. The reference model is an associative array
// plus "most recent read value"; data_out at cycle c+L-1 must equal the
// most recent read value as of edge c.
module tb_simple_dual_port_ram;
   localparam int DW = 8;
   localparam int AW = 9;

   typedef struct {
      int          due;
      logic [DW-1:0] exp;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   exp_t          q3[$];
   exp_t          q2[$];
   logic [DW-1:0] model_mem [int];
   int            wlist[$];
   logic [DW-1:0] last_rd;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   simple_dual_port_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus3 ();
   simple_dual_port_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

   simple_dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(3)) u_dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus3)
   );

   simple_dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(2)) u_dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %02h expected %02h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock of stimulus, applied on the falling edge; the model is updated
   // for the rising edge that follows and expectations are queued.
   task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic re, input logic [AW-1:0] ra);
      int e;
      logic [DW-1:0] rv;
      exp_t x;
      @(negedge clk);
      bus3.write_enable = we; bus3.write_addr = wa; bus3.data_in = wd;
      bus3.read_enable  = re; bus3.read_addr  = ra;
      bus2.write_enable = we; bus2.write_addr = wa; bus2.data_in = wd;
      bus2.read_enable  = re; bus2.read_addr  = ra;
      e = cyc + 1;
      if (re) begin
         rv = model_mem.exists(int'(ra)) ? model_mem[int'(ra)] : '0;
`ifdef RAM_RDW_BYPASS_EN
         if (we && wa == ra) rv = wd;
`endif
         last_rd = rv;
      end
      if (we) begin
         if (!model_mem.exists(int'(wa))) wlist.push_back(int'(wa));
         model_mem[int'(wa)] = wd;
      end
      x.exp = last_rd;
      x.due = e + 2; q3.push_back(x);
      x.due = e + 1; q2.push_back(x);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0);
   endtask

   // Monitor: compare data_out against whatever expectation is due this cycle.
   always @(negedge clk) begin
      if (reset) begin
         while (q3.size() > 0 && q3[0].due <= cyc) begin
            if (q3[0].due == cyc) check("lat3_data_out", bus3.data_out, q3[0].exp);
            void'(q3.pop_front());
         end
         while (q2.size() > 0 && q2[0].due <= cyc) begin
            if (q2[0].due == cyc) check("lat2_data_out", bus2.data_out, q2[0].exp);
            void'(q2.pop_front());
         end
      end
   end

   initial begin
      logic          we, re;
      logic [AW-1:0] wa, ra;
      logic [DW-1:0] wd;

      reset   = 1'b0;
      last_rd = '0;
      bus3.write_enable = 1'b0; bus3.write_addr = '0; bus3.data_in = '0;
      bus3.read_enable  = 1'b0; bus3.read_addr  = '0;
      bus2.write_enable = 1'b0; bus2.write_addr = '0; bus2.data_in = '0;
      bus2.read_enable  = 1'b0; bus2.read_addr  = '0;
      repeat (2) @(negedge clk);
      check("reset_lat3", bus3.data_out, 8'h00);
      check("reset_lat2", bus2.data_out, 8'h00);
      reset = 1'b1;

      // Basic latency: 0x3C must not appear before the expected edge.
      drive(1'b1, 9'd5, 8'h3C, 1'b0, '0);
      drive(1'b0, '0, '0, 1'b1, 9'd5);
      idle(3);

      // Streaming reads after a burst of writes.
      for (int i = 0; i < 8; i++) drive(1'b1, AW'(i), DW'(8'h10 + i), 1'b0, '0);
      for (int i = 0; i < 8; i++) drive(1'b0, '0, '0, 1'b1, AW'(i));

      // Hold: single read then idle; an overwrite must not disturb data_out.
      drive(1'b0, '0, '0, 1'b1, 9'd2);
      for (int i = 0; i < 10; i++) drive(i == 4, 9'd2, 8'hFF, 1'b0, '0);

      // Same-address read-during-write, then a plain re-read.
      drive(1'b1, 9'd9, 8'h01, 1'b0, '0);
      drive(1'b1, 9'd9, 8'h02, 1'b1, 9'd9);
      idle(3);
      drive(1'b0, '0, '0, 1'b1, 9'd9);
      idle(3);

      // Address extremes must not alias.
      drive(1'b1, 9'd0,   8'h55, 1'b0, '0);
      drive(1'b1, 9'd511, 8'hAA, 1'b0, '0);
      drive(1'b0, '0, '0, 1'b1, 9'd0);
      drive(1'b0, '0, '0, 1'b1, 9'd511);
      idle(3);

      // Asynchronous reset mid-cycle with 0xA5 filling the pipeline.
      drive(1'b1, 9'd20, 8'hA5, 1'b0, '0);
      drive(1'b0, '0, '0, 1'b1, 9'd20);
      idle(4);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("async_reset_lat3", bus3.data_out, 8'h00);
      check("async_reset_lat2", bus2.data_out, 8'h00);
      q3.delete();
      q2.delete();
      last_rd = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_hold_lat3", bus3.data_out, 8'h00);
         check("reset_hold_lat2", bus2.data_out, 8'h00);
      end
      reset = 1'b1;
      idle(1);
      drive(1'b0, '0, '0, 1'b1, 9'd20);
      idle(3);

      // Randomized traffic; reads only target addresses already written.
      for (int n = 0; n < 400; n++) begin
         we = 1'($urandom_range(0, 1));
         wa = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom);
         wd = DW'($urandom);
         re = 1'b0;
         ra = '0;
         if (wlist.size() > 0 && $urandom_range(0, 3) != 0) begin
            re = 1'b1;
            ra = AW'(wlist[$urandom_range(0, wlist.size() - 1)]);
            if (we && model_mem.exists(int'(wa)) && $urandom_range(0, 3) == 0) ra = wa;
         end
         drive(we, wa, wd, re, ra);
      end
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
